// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Define ID_EX_FORWARD_EN to enable the forwarding network; without it a full interlock stalls instead.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [2:0]            id_aluctrl,
  input  logic                  id_alusrc,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memwrite,
  input  logic                  id_branch,
  input  logic                  flush,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_result,
  output logic                  load_use_stall,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  output logic [2:0]            ALUctrl,
  output logic                  ex_valid,
  output logic                  ex_regwrite,
  output logic                  ex_memread,
  output logic                  ex_memwrite,
  output logic                  ex_branch,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0] ex_store_data
);

  logic                  ex_alusrc;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2;
  logic [DATA_WIDTH-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;
  logic                  take;

`ifdef ID_EX_FORWARD_EN
  assign load_use_stall = id_valid & ex_valid & ex_memread & (ex_rd != '0) &
                          ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  always_comb begin
    fwd_rs1 = ex_rs1_data;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1))
      fwd_rs1 = mem_result;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1))
      fwd_rs1 = wb_result;
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2))
      fwd_rs2 = mem_result;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2))
      fwd_rs2 = wb_result;
  end
`else
  logic hit_rs1, hit_rs2;
  logic unused_fwd;

  // WB producers need no stall: the register file writes before it is read.
  assign hit_rs1 = (id_rs1 != '0) &
                   ((ex_valid & ex_regwrite & (ex_rd == id_rs1)) | (mem_regwrite & (mem_rd == id_rs1)));
  assign hit_rs2 = (id_rs2 != '0) &
                   ((ex_valid & ex_regwrite & (ex_rd == id_rs2)) | (mem_regwrite & (mem_rd == id_rs2)));
  assign load_use_stall = id_valid & (hit_rs1 | hit_rs2);

  assign fwd_rs1    = ex_rs1_data;
  assign fwd_rs2    = ex_rs2_data;
  assign unused_fwd = ^{mem_result, wb_regwrite, wb_rd, wb_result, ex_rs1, ex_rs2};
`endif

  assign ALUop1        = fwd_rs1;
  assign ALUop2        = ex_alusrc ? ex_imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;

  // Bubbles and invalid slots share one path: controls gated off, data fields loaded regardless.
  assign take = id_valid & ~flush & ~load_use_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      ex_alusrc   <= 1'b0;
      ALUctrl     <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
    end else begin
      ex_valid    <= take;
      ex_regwrite <= take & id_regwrite;
      ex_memread  <= take & id_memread;
      ex_memwrite <= take & id_memwrite;
      ex_branch   <= take & id_branch;
      ex_alusrc   <= take & id_alusrc;
      ALUctrl     <= take ? id_aluctrl : 3'b000;
      ex_rd       <= id_rd;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, hand-written hazard sequences, random vs model.
// Follows the ID_EX_FORWARD_EN setting of the build for forwarding/interlock expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [2:0]  id_aluctrl;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_branch;
  logic        flush;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        load_use_stall;
  logic [31:0] ALUop1, ALUop2, ex_store_data;
  logic [2:0]  ALUctrl;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_aluctrl(id_aluctrl), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
    .flush(flush), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_rd(ex_rd),
    .ex_store_data(ex_store_data)
  );

  // Reference: the instruction the EX stage is expected to hold.
  typedef struct packed {
    logic        valid, regw, memr, memw, br, alusrc;
    logic [2:0]  ctrl;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] d1, d2, imm;
  } ex_t;
  ex_t m;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [2:0]  ctrl;
    logic        alusrc, regw, memr, memw, br, fl;
    logic        e_valid, e_regw, e_memr, e_memw, e_br;
    logic [2:0]  e_ctrl;
    logic [31:0] e_op1, e_op2, e_store;
    logic [4:0]  e_rd;
    logic        chk_data;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_aluctrl = 0;
    id_alusrc = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_branch = 0;
    flush = 0; mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_regwrite = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [2:0] ctrl, input logic src, input logic rw, input logic mr,
                        input logic mw, input logic br);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_aluctrl = ctrl;
    id_alusrc = src; id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_branch = br;
  endtask

  function automatic logic model_stall();
    logic a1, a2;
`ifdef ID_EX_FORWARD_EN
    return id_valid && m.valid && m.memr && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2);
`else
    a1 = id_rs1 != 0 && ((m.valid && m.regw && m.rd == id_rs1) || (mem_regwrite && mem_rd == id_rs1));
    a2 = id_rs2 != 0 && ((m.valid && m.regw && m.rd == id_rs2) || (mem_regwrite && mem_rd == id_rs2));
    return id_valid && (a1 || a2);
`endif
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] idx, input logic [31:0] regd);
`ifdef ID_EX_FORWARD_EN
    if (mem_regwrite && mem_rd != 0 && mem_rd == idx) return mem_result;
    if (wb_regwrite && wb_rd != 0 && wb_rd == idx) return wb_result;
`endif
    return regd;
  endfunction

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    ex_t nx;
    nx = '0;
    if (!flush && !model_stall() && id_valid) begin
      nx.valid = 1; nx.regw = id_regwrite; nx.memr = id_memread; nx.memw = id_memwrite;
      nx.br = id_branch; nx.alusrc = id_alusrc; nx.ctrl = id_aluctrl; nx.rd = id_rd;
      nx.rs1 = id_rs1; nx.rs2 = id_rs2; nx.d1 = id_rs1_data; nx.d2 = id_rs2_data; nx.imm = id_imm;
    end
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic check_model();
    logic [31:0] f2;
    chk("rnd_stall", load_use_stall, model_stall());
    chk("rnd_valid", ex_valid, m.valid);
    chk("rnd_regwrite", ex_regwrite, m.regw);
    chk("rnd_memread", ex_memread, m.memr);
    chk("rnd_memwrite", ex_memwrite, m.memw);
    chk("rnd_branch", ex_branch, m.br);
    if (m.valid) begin
      f2 = model_fwd(m.rs2, m.d2);
      chk("rnd_aluctrl", ALUctrl, m.ctrl);
      chk("rnd_rd", ex_rd, m.rd);
      chk("rnd_op1", ALUop1, model_fwd(m.rs1, m.d1));
      chk("rnd_op2", ALUop2, m.alusrc ? m.imm : f2);
      chk("rnd_store", ex_store_data, f2);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_op1"}, ALUop1, 0);
    chk({tag, "_op2"}, ALUop2, 0);
    chk({tag, "_store"}, ex_store_data, 0);
    chk({tag, "_ctrl"}, ALUctrl, 0);
    chk({tag, "_ctl"}, {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch}, 0);
    chk({tag, "_rd"}, ex_rd, 0);
    chk({tag, "_stall"}, load_use_stall, 0);
  endtask

  initial begin
    m = '0;
    idle_inputs();
    rst_n = 0;
    #12;
    check_all_zero("reset");
    rst_n = 1;
    @(posedge clk); #1;

    //          v rs1 rs2 rd  d1           d2           imm          ctl src rw mr mw br fl | e_v rw mr mw br ctl op1         op2          store        rd chk
    vecs[0] = '{1, 5,  6,  9, 7,           3,           0,           0,  0,  1, 0, 0, 0, 0,  1,  1, 0, 0, 0, 0,  7,          3,           3,           9, 1};
    vecs[1] = '{1, 2,  3, 10, 32'h1234,    32'h55,      32'hFFFFFFF0, 1, 1,  1, 0, 0, 0, 0,  1,  1, 0, 0, 0, 1,  32'h1234,   32'hFFFFFFF0, 32'h55,     10, 1};
    vecs[2] = '{1, 4,  7,  0, 32'h100,     32'hDEADBEEF, 8,          0,  1,  0, 0, 1, 0, 0,  1,  0, 0, 1, 0, 0,  32'h100,    8,           32'hDEADBEEF, 0, 1};
    vecs[3] = '{1, 1,  0,  8, 32'h2000,    0,           4,           0,  1,  1, 1, 0, 0, 0,  1,  1, 1, 0, 0, 0,  32'h2000,   4,           0,           8, 1};
    vecs[4] = '{1, 11, 12, 0, 32'hA,       32'hB,       32'h40,      1,  0,  0, 0, 0, 1, 0,  1,  0, 0, 0, 1, 1,  32'hA,      32'hB,       32'hB,       0, 1};
    vecs[5] = '{0, 1,  2,  3, 1,           2,           3,           0,  0,  1, 1, 1, 1, 0,  0,  0, 0, 0, 0, 0,  0,          0,           0,           0, 0};
    vecs[6] = '{1, 1,  2,  3, 1,           2,           3,           0,  0,  1, 1, 1, 1, 1,  0,  0, 0, 0, 0, 0,  0,          0,           0,           0, 0};

    foreach (vecs[i]) begin
      idle_inputs();
      tick();
      set_id(vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].d1, vecs[i].d2,
             vecs[i].imm, vecs[i].ctrl, vecs[i].alusrc, vecs[i].regw, vecs[i].memr,
             vecs[i].memw, vecs[i].br);
      flush = vecs[i].fl;
      #1;
      chk("vec_stall", load_use_stall, 0);
      tick();
      chk("vec_valid", ex_valid, vecs[i].e_valid);
      chk("vec_ctl", {ex_regwrite, ex_memread, ex_memwrite, ex_branch},
          {vecs[i].e_regw, vecs[i].e_memr, vecs[i].e_memw, vecs[i].e_br});
      if (vecs[i].chk_data) begin
        chk("vec_aluctrl", ALUctrl, vecs[i].e_ctrl);
        chk("vec_op1", ALUop1, vecs[i].e_op1);
        chk("vec_op2", ALUop2, vecs[i].e_op2);
        chk("vec_store", ex_store_data, vecs[i].e_store);
        chk("vec_rd", ex_rd, vecs[i].e_rd);
      end
    end

    // Asynchronous reset mid-stream discards a valid EX instruction.
    idle_inputs();
    set_id(1, 5, 6, 9, 7, 3, 0, 0, 0, 1, 0, 0, 0);
    tick();
    idle_inputs();
    chk("pre_reset_valid", ex_valid, 1);
    #2 rst_n = 0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1;
    m = '0;
    @(posedge clk); #1;

    // Forwarding priority on a held EX instruction (combinational only).
    idle_inputs();
    set_id(1, 4, 0, 9, 32'h99, 32'h5, 0, 0, 0, 1, 0, 0, 0);
    tick();
    idle_inputs();
    mem_regwrite = 1; mem_rd = 4; mem_result = 32'h11;
    wb_regwrite = 1; wb_rd = 4; wb_result = 32'h22;
    #1;
`ifdef ID_EX_FORWARD_EN
    chk("fwd_mem_over_wb", ALUop1, 32'h11);
    mem_rd = 0; #1;
    chk("fwd_wb", ALUop1, 32'h22);
`else
    chk("nofwd_mem", ALUop1, 32'h99);
    mem_rd = 0; #1;
    chk("nofwd_wb", ALUop1, 32'h99);
`endif
    wb_rd = 0; #1;
    chk("fwd_x0_rs2", ex_store_data, 32'h5);
    idle_inputs();
    set_id(1, 0, 0, 9, 32'h77, 32'h5, 0, 0, 0, 1, 0, 0, 0);
    tick();
    idle_inputs();
    mem_regwrite = 1; mem_rd = 0; mem_result = 32'h11;
    #1;
    chk("fwd_x0_rs1", ALUop1, 32'h77);
    idle_inputs();

`ifdef ID_EX_FORWARD_EN
    // Load-use: one stall cycle, bubble, then the dependent add picks up the load from WB.
    set_id(1, 1, 0, 8, 32'h2000, 0, 4, 0, 1, 1, 1, 0, 0);
    tick();
    set_id(1, 2, 8, 9, 32'h10, 32'hBAD, 0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("lu_stall", load_use_stall, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_ctl", {ex_regwrite, ex_memread, ex_memwrite, ex_branch}, 0);
    mem_regwrite = 1; mem_rd = 8; mem_result = 32'h2004;
    #1;
    chk("lu_stall_released", load_use_stall, 0);
    tick();
    idle_inputs();
    wb_regwrite = 1; wb_rd = 8; wb_result = 32'hABCD;
    #1;
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_op2", ALUop2, 32'hABCD);
    chk("lu_add_store", ex_store_data, 32'hABCD);
    chk("lu_add_op1", ALUop1, 32'h10);
`else
    // Full interlock: dependent sub stalls while the producer sits in EX and then in MEM.
    set_id(1, 1, 2, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    set_id(1, 3, 0, 4, 32'h30, 0, 0, 1, 0, 1, 0, 0, 0);
    #1;
    chk("il_stall_ex", load_use_stall, 1);
    tick();
    chk("il_bubble1", ex_valid, 0);
    mem_regwrite = 1; mem_rd = 3;
    #1;
    chk("il_stall_mem", load_use_stall, 1);
    tick();
    chk("il_bubble2", ex_valid, 0);
    mem_regwrite = 0; mem_rd = 0; wb_regwrite = 1; wb_rd = 3;
    #1;
    chk("il_no_stall_wb", load_use_stall, 0);
    tick();
    idle_inputs();
    #1;
    chk("il_sub_valid", ex_valid, 1);
    chk("il_sub_ctrl", ALUctrl, 3'b001);
    chk("il_sub_op1", ALUop1, 32'h30);
`endif

    // Flush and stall in the same cycle: stall still visible upstream, EX gets a bubble.
    idle_inputs();
    set_id(1, 1, 0, 8, 32'h2000, 0, 4, 0, 1, 1, 1, 0, 0);
    tick();
    set_id(1, 2, 8, 9, 32'h10, 32'h20, 0, 0, 0, 1, 0, 1, 1);
    flush = 1;
    #1;
    chk("fs_stall", load_use_stall, 1);
    tick();
    chk("fs_valid", ex_valid, 0);
    chk("fs_ctl", {ex_regwrite, ex_memread, ex_memwrite, ex_branch}, 0);

    // Randomized traffic against the model; small register range to provoke hazards.
    for (int unsigned k = 0; k < 400; k++) begin
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 3'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      flush = $urandom_range(0, 9) == 0;
      mem_regwrite = 1'($urandom_range(0, 1)); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
      wb_regwrite = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
      #2;
      check_model();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
